// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states
// and the mux/ALU select codes driven into the datapath.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/control_output_decoder.sv
// Moore output decode: datapath controls from the current state, with memory
// stall suppressing the fetch write enables.
module control_output_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       stall,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       mem_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src
);

    always_comb begin
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_src     = PCSRC_ALU;
        case (state_t'(state))
            S_FETCH: begin
                // A stalled fetch must not latch a half-read instruction or bump PC.
                ir_write  = ~stall;
                pc_write  = ~stall;
                alu_src_b = SRCB_FOUR;
            end
            S_DECODE: alu_src_b = SRCB_BROFF;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: state register and next-state logic; output
// decoding lives in control_output_decoder.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int SUPPORT_ADDI = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode_i,
    input  logic       Stall_i,
    output logic       IorD_o,
    output logic       IR_Write_o,
    output logic       PC_Write_o,
    output logic       Branch_o,
    output logic       Mem_Write_o,
    output logic       Reg_Dst_o,
    output logic       Mem_to_Reg_o,
    output logic       Reg_Write_o,
    output logic       ALU_Src_A_o,
    output logic [1:0] ALU_Src_B_o,
    output logic [1:0] ALU_Op_o,
    output logic [1:0] PC_Src_o,
    output logic       Illegal_o,
    output logic [3:0] State_o
);

    state_t state_reg;
    state_t state_next;
    logic   illegal;

    logic       dec_iord, dec_ir_write, dec_pc_write, dec_branch, dec_mem_write;
    logic       dec_reg_dst, dec_mem_to_reg, dec_reg_write, dec_alu_src_a;
    logic [1:0] dec_alu_src_b, dec_alu_op, dec_pc_src;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        illegal    = 1'b0;
        case (state_reg)
            S_FETCH:   state_next = Stall_i ? S_FETCH : S_DECODE;
            S_DECODE: begin
                case (Opcode_i)
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI: begin
                        if (SUPPORT_ADDI != 0) state_next = S_ADDIEX;
                        else                   illegal    = 1'b1;
                    end
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEMADR:  state_next = (Opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = Stall_i ? S_MEMRD : S_MEMWB;
            S_MEMWR:   state_next = Stall_i ? S_MEMWR : S_FETCH;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    control_output_decoder u_decoder (
        .state      (state_reg),
        .stall      (Stall_i),
        .iord       (dec_iord),
        .ir_write   (dec_ir_write),
        .pc_write   (dec_pc_write),
        .branch     (dec_branch),
        .mem_write  (dec_mem_write),
        .reg_dst    (dec_reg_dst),
        .mem_to_reg (dec_mem_to_reg),
        .reg_write  (dec_reg_write),
        .alu_src_a  (dec_alu_src_a),
        .alu_src_b  (dec_alu_src_b),
        .alu_op     (dec_alu_op),
        .pc_src     (dec_pc_src)
    );

    // FETCH still decodes write enables, so everything is blanked while reset is held.
    assign IorD_o       = reset & dec_iord;
    assign IR_Write_o   = reset & dec_ir_write;
    assign PC_Write_o   = reset & dec_pc_write;
    assign Branch_o     = reset & dec_branch;
    assign Mem_Write_o  = reset & dec_mem_write;
    assign Reg_Dst_o    = reset & dec_reg_dst;
    assign Mem_to_Reg_o = reset & dec_mem_to_reg;
    assign Reg_Write_o  = reset & dec_reg_write;
    assign ALU_Src_A_o  = reset & dec_alu_src_a;
    assign ALU_Src_B_o  = {2{reset}} & dec_alu_src_b;
    assign ALU_Op_o     = {2{reset}} & dec_alu_op;
    assign PC_Src_o     = {2{reset}} & dec_pc_src;
    assign Illegal_o    = reset & illegal;
    assign State_o      = state_reg;

endmodule
